// File: rtl/mem_stream_port.sv
// mem_stream_port
//   Streaming front-end for one single-ported coefficient memory bank.
//   LOAD   : accepts a valid/ready input stream and writes DEPTH words to
//            addresses 0..DEPTH-1.
//   UNLOAD : reads the bank at ascending addresses and presents the words on
//            a valid/ready output stream. A 2-entry FIFO absorbs the bank's
//            one-cycle read latency and downstream back-pressure.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start_load, start_unload  transfer start pulses (honoured only when idle)
//   busy, done                busy while transferring; done pulses at the end
//   s_data/s_valid/s_ready    input stream (LOAD)
//   m_data/m_valid/m_ready    output stream (UNLOAD)
//   mem_di/mem_addr/mem_en/mem_we  bank control pins
//   mem_do                    bank read data, valid the cycle after a read
module mem_stream_port #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_load,
   input  logic             start_unload,
   output logic             busy,
   output logic             done,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] mem_di,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_en,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_do
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_UNLOAD = 2'd2;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;     // bank address counter
   logic [AW-1:0]    xfer_q, xfer_d;     // words popped during UNLOAD
   logic             rd_all_q, rd_all_d; // all DEPTH reads have been issued
   logic             infl_q, infl_d;     // read issued last cycle, data on mem_do now
   logic [1:0]       occ_q, occ_d;       // FIFO occupancy
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] fifo_q [2];
   logic [WIDTH-1:0] fifo_d [2];
   logic             done_q, done_d;

   logic             wr;
   logic             rd_issue;
   logic             pop;
   logic             push;
   logic [2:0]       level;

   assign m_valid = (occ_q != 2'd0);
   assign m_data  = fifo_q[rd_ptr_q];
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign s_ready = (state_q == ST_LOAD);

   assign pop  = (state_q == ST_UNLOAD) && m_valid && m_ready;
   assign push = infl_q;
   assign wr   = (state_q == ST_LOAD) && s_valid;

   // Entries that will still be held once this cycle's pop and the pending
   // in-flight push settle; a new read is only safe while that is below 2.
   assign level    = 3'(occ_q) + 3'(infl_q) - 3'(pop);
   assign rd_issue = (state_q == ST_UNLOAD) && !rd_all_q && (level < 3'd2);

   always_comb begin
      mem_en   = wr || rd_issue;
      mem_we   = wr;
      mem_addr = busy ? addr_q : '0;
      mem_di   = (state_q == ST_LOAD) ? s_data : '0;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      xfer_d   = xfer_q;
      rd_all_d = rd_all_q;
      infl_d   = 1'b0;
      occ_d    = occ_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      fifo_d   = fifo_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_load) begin
               state_d = ST_LOAD;
            end else if (start_unload) begin
               state_d = ST_UNLOAD;
            end
         end

         ST_LOAD: begin
            if (wr) begin
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_UNLOAD: begin
            infl_d = rd_issue;
            if (rd_issue) begin
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) begin
                  rd_all_d = 1'b1;
               end
            end
            if (push) begin
               fifo_d[wr_ptr_q] = mem_do;
               wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_d = ~rd_ptr_q;
               xfer_d   = xfer_q + 1'b1;
               if (xfer_q == LAST_ADDR) begin
                  state_d  = ST_IDLE;
                  done_d   = 1'b1;
                  rd_all_d = 1'b0;
               end
            end
            occ_d = occ_q + 2'(push) - 2'(pop);
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         xfer_q   <= '0;
         rd_all_q <= 1'b0;
         infl_q   <= 1'b0;
         occ_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         fifo_q   <= '{default: '0};
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         xfer_q   <= xfer_d;
         rd_all_q <= rd_all_d;
         infl_q   <= infl_d;
         occ_q    <= occ_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fifo_q   <= fifo_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_mem_stream_port.sv
module tb_mem_stream_port;

   localparam int WIDTH = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_load = 1'b0;
   logic             start_unload = 1'b0;
   logic             busy, done;
   logic [WIDTH-1:0] s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready = 1'b1;
   logic [WIDTH-1:0] mem_di;
   logic [AW-1:0]    mem_addr;
   logic             mem_en, mem_we;
   logic [WIDTH-1:0] mem_do;

   always #5 clk = ~clk;

   mem_stream_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start_load(start_load), .start_unload(start_unload),
      .busy(busy), .done(done),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .mem_di(mem_di), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
      .mem_do(mem_do)
   );

   // Bank: registered read, output held when not enabled.
   logic [WIDTH-1:0] bank [DEPTH];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) bank[mem_addr] <= mem_di;
         else        mem_do <= bank[mem_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: phase, words written, words popped, expected bank.
   int               phase = 0;     // 0 idle, 1 load, 2 unload
   int               wcnt = 0;
   int               popcnt = 0;
   int               ucyc = 0;
   int               outst = 0;
   int               rds = 0;
   int               busy_cycles = 0;
   bit               exp_done = 0;
   bit               full_rate = 0;
   logic [WIDTH-1:0] refm [DEPTH];

   always @(negedge clk) begin
      bit pop, exp_done_n;
      pop = m_valid && m_ready;
      check("busy", busy, phase != 0);
      check("done", done, exp_done);
      check("s_ready", s_ready, phase == 1);
      case (phase)
         0: begin
            check("idle_mem_en", mem_en, 0);
            check("idle_m_valid", m_valid, 0);
         end
         1: begin
            check("load_we", mem_we, s_valid);
            check("load_en", mem_en, s_valid);
            check("load_m_valid", m_valid, 0);
            if (s_valid) begin
               check("load_addr", mem_addr, wcnt);
               check("load_di", mem_di, s_data);
            end
         end
         default: begin
            check("unload_we", mem_we, 0);
            if (full_rate) check("unload_m_valid", m_valid, ucyc >= 2);
            if (pop) check("unload_data", m_data, refm[popcnt]);
            if (mem_en) begin
               check("unload_addr", mem_addr, rds % DEPTH);
               rds++;
               check("unload_read_count_le_depth", rds <= DEPTH, 1);
            end
            outst = outst + int'(mem_en) - int'(pop);
            check("unload_outstanding_le2", outst <= 2, 1);
         end
      endcase
      if (busy) busy_cycles++;

      exp_done_n = 0;
      if (rst) begin
         phase = 0; wcnt = 0; popcnt = 0;
      end else begin
         case (phase)
            0: begin
               if (start_load) begin
                  phase = 1; wcnt = 0;
               end else if (start_unload) begin
                  phase = 2; popcnt = 0; ucyc = 0; outst = 0; rds = 0;
               end
            end
            1: begin
               if (s_valid) begin
                  refm[wcnt] = s_data;
                  wcnt++;
                  if (wcnt == DEPTH) begin phase = 0; exp_done_n = 1; end
               end
            end
            default: begin
               ucyc++;
               if (pop) begin
                  popcnt++;
                  if (popcnt == DEPTH) begin phase = 0; exp_done_n = 1; end
               end
            end
         endcase
      end
      exp_done = exp_done_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_unload(input bit full);
      bit fin;
      full_rate    = full;
      start_unload = 1'b1;
      m_ready      = 1'b1;
      tick();
      start_unload = 1'b0;
      busy_cycles  = 0;
      fin = 0;
      for (int c = 0; c < 600 && !fin; c++) begin
         m_ready = full ? 1'b1 : ($urandom_range(0, 9) >= 3);
         tick();
         if (done) fin = 1;
      end
      check("unload_completed", fin, 1);
      check("unload_total_reads", rds, DEPTH);
      if (full) check("unload_busy_cycles", busy_cycles, DEPTH + 2);
      full_rate = 0;
      m_ready   = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_di", mem_di, 0);

      // Full-rate LOAD of 1..64.
      start_load = 1'b1;
      tick();
      start_load  = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < DEPTH; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 1);
         tick();
      end
      s_valid = 1'b0;
      check("load1_done_pulse", done, 1);
      check("load1_busy_low", busy, 0);
      check("load1_busy_cycles", busy_cycles, DEPTH);
      tick();
      check("load1_done_once", done, 0);
      check("bank0", bank[0], 8'd1);
      check("bank31", bank[31], 8'd32);
      check("bank63", bank[63], 8'd64);

      do_unload(1'b1);
      do_unload(1'b0);

      // Both starts together: LOAD wins. start_unload mid-LOAD ignored.
      start_load   = 1'b1;
      start_unload = 1'b1;
      tick();
      start_load   = 1'b0;
      start_unload = 1'b0;
      check("both_starts_load", s_ready, 1);
      for (int k = 0; k < 2 * DEPTH; k++) begin
         s_valid      = (k % 2 == 0);
         s_data       = s_valid ? 8'((k / 2) * 3 + 7) : 8'hEE;
         start_unload = (k == 10);
         tick();
         check("toggle_done", done, k == 2 * DEPTH - 2);
      end
      s_valid      = 1'b0;
      start_unload = 1'b0;
      check("toggle_idle_after", busy, 0);
      check("toggle_bank1", bank[1], 8'd10);
      check("toggle_bank63", bank[63], 8'd196);
      tick();

      do_unload(1'b0);

      // Abort LOAD after 10 writes.
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h50 + i);
         tick();
      end
      s_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_s_ready", s_ready, 0);
      check("abort_m_valid", m_valid, 0);
      check("abort_m_data", m_data, 0);
      check("abort_mem_en", mem_en, 0);
      check("abort_mem_we", mem_we, 0);
      check("abort_mem_addr", mem_addr, 0);
      check("abort_mem_di", mem_di, 0);
      check("abort_bank9_kept", bank[9], 8'h59);
      tick();
      check("abort_no_done", done, 0);

      // Fresh LOAD starts at address 0.
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      s_valid    = 1'b1;
      s_data     = 8'h77;
      #1;
      check("fresh_addr0", mem_addr, 0);
      check("fresh_we", mem_we, 1);
      for (int i = 0; i < DEPTH; i++) begin
         s_data = 8'(8'h77 + i);
         tick();
      end
      s_valid = 1'b0;
      check("fresh_done", done, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
